// File: rtl/fft_stage_sequencer.sv
// Radix-2 DIT FFT stage/butterfly sequencer with drain gaps.
// Optional bit-reverse output phase: define FFT_BITREV_EN.
module fft_stage_sequencer #(
  parameter int MAX_N      = 32,
  parameter int ADDR_WIDTH = $clog2(MAX_N),
  parameter int BF_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   n_points,
  input  logic                  fmt_in,
  input  logic                  bf_ready,
  output logic                  bf_valid,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [ADDR_WIDTH-1:0] tw_k,
  output logic [ADDR_WIDTH:0]   tw_n,
  output logic                  tw_fmt,
  output logic [2:0]            stage,
`ifdef FFT_BITREV_EN
  output logic                  br_valid,
  output logic [ADDR_WIDTH-1:0] br_addr,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int AW = ADDR_WIDTH;
  localparam int CW = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;

  typedef enum logic [2:0] {
    IDLE, ISSUE, DRAIN, BITREV, FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] j_q, j_d;
  logic [2:0]    stg_q, stg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    l_q, l_in, l_eff;
  logic          legal, accept, fire, last_bf;
`ifdef FFT_BITREV_EN
  logic [AW-1:0] i_q, i_d, rev;
  logic          br_valid_d;
  logic [AW-1:0] br_addr_d;
`endif

  logic          bf_valid_d, busy_d, done_d, err_d, tw_fmt_d;
  logic [AW-1:0] addr_a_d, addr_b_d, tw_k_d;
  logic [AW-1:0] half, pos, grp, a_calc;
  logic [AW:0]   tw_n_d;

  assign stage = stg_q;
  assign fire  = bf_valid & bf_ready;
  assign legal = (n_points >= (AW+1)'(2))
              && (n_points <= (AW+1)'(MAX_N))
              && ((n_points & (n_points - (AW+1)'(1))) == '0);
  assign accept  = (state_q == IDLE) && start && legal;
  assign last_bf = (j_q == AW'((tw_n >> 1) - (AW+1)'(1)));
  assign l_eff   = accept ? l_in : l_q;

  // log2 of the requested size (only meaningful when legal)
  always_comb begin
    l_in = '0;
    for (int b = 0; b <= AW; b++)
      if (n_points[b]) l_in = 3'(b);
  end

  // state and loop-counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      j_q     <= '0;
      stg_q   <= '0;
      cnt_q   <= '0;
      l_q     <= '0;
`ifdef FFT_BITREV_EN
      i_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      stg_q   <= stg_d;
      cnt_q   <= cnt_d;
      if (accept) l_q <= l_in;
`ifdef FFT_BITREV_EN
      i_q     <= i_d;
`endif
    end
  end

  // next-state and counter sequencing
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    stg_d   = stg_q;
    cnt_d   = cnt_q;
`ifdef FFT_BITREV_EN
    i_d     = i_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ISSUE;
          j_d     = '0;
          stg_d   = '0;
        end
      end
      ISSUE: begin
        if (fire) begin
          if (last_bf) begin
            state_d = DRAIN;
            j_d     = '0;
            cnt_d   = '0;
          end else begin
            j_d = j_q + AW'(1);
          end
        end
      end
      DRAIN: begin
        if (cnt_q == CW'(BF_LATENCY - 1)) begin
          if (stg_q == l_q - 3'd1) begin
`ifdef FFT_BITREV_EN
            state_d = BITREV;
            i_d     = '0;
`else
            state_d = FINISH;
`endif
          end else begin
            stg_d   = stg_q + 3'd1;
            state_d = ISSUE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BITREV: begin
`ifdef FFT_BITREV_EN
        if (bf_ready) begin
          if (i_q == AW'(tw_n - (AW+1)'(1)))
            state_d = FINISH;
          else
            i_d = i_q + AW'(1);
        end
`else
        state_d = IDLE;
`endif
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // next values of the registered outputs
  always_comb begin
    half   = AW'(1) << stg_d;
    pos    = j_d & (half - AW'(1));
    grp    = j_d >> stg_d;
    a_calc = (grp << (stg_d + 3'd1)) | pos;

    bf_valid_d = (state_d == ISSUE);
    addr_a_d   = bf_valid_d ? a_calc : addr_a;
    addr_b_d   = bf_valid_d ? (a_calc + half) : addr_b;
    tw_k_d     = bf_valid_d ? (pos << (l_eff - 3'd1 - stg_d)) : tw_k;
    tw_n_d     = accept ? n_points : tw_n;
    tw_fmt_d   = accept ? fmt_in : tw_fmt;
    busy_d     = (state_d != IDLE);
    done_d     = (state_q == FINISH);
    err_d      = (state_q == IDLE) && start && !legal;
`ifdef FFT_BITREV_EN
    for (int b = 0; b < AW; b++)
      rev[b] = i_d[AW-1-b];
    br_valid_d = (state_d == BITREV);
    br_addr_d  = br_valid_d ? (rev >> (3'(AW) - l_q)) : br_addr;
`endif
  end

  // output register
  always_ff @(posedge clk) begin
    if (rst) begin
      bf_valid <= 1'b0;
      addr_a   <= '0;
      addr_b   <= '0;
      tw_k     <= '0;
      tw_n     <= '0;
      tw_fmt   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef FFT_BITREV_EN
      br_valid <= 1'b0;
      br_addr  <= '0;
`endif
    end else begin
      bf_valid <= bf_valid_d;
      addr_a   <= addr_a_d;
      addr_b   <= addr_b_d;
      tw_k     <= tw_k_d;
      tw_n     <= tw_n_d;
      tw_fmt   <= tw_fmt_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
`ifdef FFT_BITREV_EN
      br_valid <= br_valid_d;
      br_addr  <= br_addr_d;
`endif
    end
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer.
// Scoreboard of expected butterfly issues, directed steps.
module tb_fft_stage_sequencer;

  localparam int MAX_N = 32;
  localparam int AW    = 5;
  localparam int LAT   = 4;

  logic          clk = 1'b0;
  logic          rst, start, fmt_in, bf_ready;
  logic [AW:0]   n_points;
  logic          bf_valid, tw_fmt, busy, done, err;
  logic [AW-1:0] addr_a, addr_b, tw_k;
  logic [AW:0]   tw_n;
  logic [2:0]    stage;
`ifdef FFT_BITREV_EN
  logic          br_valid;
  logic [AW-1:0] br_addr;
`endif

  fft_stage_sequencer #(
    .MAX_N(MAX_N), .ADDR_WIDTH(AW), .BF_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .n_points(n_points), .fmt_in(fmt_in),
    .bf_ready(bf_ready), .bf_valid(bf_valid),
    .addr_a(addr_a), .addr_b(addr_b),
    .tw_k(tw_k), .tw_n(tw_n), .tw_fmt(tw_fmt),
    .stage(stage),
`ifdef FFT_BITREV_EN
    .br_valid(br_valid), .br_addr(br_addr),
`endif
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [AW-1:0] k;
    logic [AW:0]   n;
    logic          fmt;
    logic [2:0]    stg;
  } iss_t;

  iss_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int log2i(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic logic [31:0] all_outs();
    return 32'({bf_valid, addr_a, addr_b, tw_k, tw_n,
                tw_fmt, stage, busy, done, err});
  endfunction

  task automatic push_model(input int n, input bit fmt);
    int L = log2i(n);
    iss_t e;
    for (int s = 0; s < L; s++) begin
      for (int j = 0; j < n / 2; j++) begin
        int hf = 1 << s;
        int ps = j % hf;
        int gp = j / hf;
        e.a   = AW'(gp * 2 * hf + ps);
        e.b   = AW'(gp * 2 * hf + ps + hf);
        e.k   = AW'(ps * (1 << (L - 1 - s)));
        e.n   = (AW+1)'(n);
        e.fmt = fmt;
        e.stg = 3'(s);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run_fft(input int n, input bit fmt, input bit stall);
    int   L     = log2i(n);
    int   cyc   = 0;
    int   xfers = 0;
    int   span  = L * (n / 2 + LAT);
    int   exp_done;
    bit   got_done = 1'b0;
    bit   held     = 1'b0;
    iss_t prev, obs, e;
`ifdef FFT_BITREV_EN
    logic [AW-1:0] br_obs[$];
    int ri = 0;
`endif
    exp_done = span + 2;
`ifdef FFT_BITREV_EN
    exp_done = exp_done + n;
`endif
    push_model(n, fmt);
    n_points = (AW+1)'(n);
    fmt_in   = fmt;
    start    = 1'b1;
    bf_ready = 1'b1;
    while (!got_done && cyc < 2000) begin
      step();
      cyc++;
      start    = 1'b0;
      n_points = 6'd3;
      fmt_in   = ~fmt;
      obs = '{addr_a, addr_b, tw_k, tw_n, tw_fmt, stage};
      if (cyc == 1) chk("busy_start", 32'(busy), 32'd1);
      if (held)
        chk("stall_hold",
            32'({bf_valid, addr_a, addr_b, tw_k}),
            32'({1'b1, prev.a, prev.b, prev.k}));
      if (!stall && cyc <= span)
        chk("valid_gap", 32'(bf_valid),
            32'(((cyc - 1) % (n / 2 + LAT)) < n / 2));
      bf_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bf_valid && bf_ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          chk("extra_issue", 32'(bf_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("issue_n%0d_%0d", n, xfers),
              32'(obs), 32'(e));
        end
      end
`ifdef FFT_BITREV_EN
      if (br_valid && bf_ready) br_obs.push_back(br_addr);
`endif
      held = bf_valid && !bf_ready;
      prev = obs;
      if (done) begin
        got_done = 1'b1;
        chk("done_busy", 32'(busy), 32'd0);
        if (!stall) chk("latency", 32'(cyc), 32'(exp_done));
      end
    end
    chk("done_seen", 32'(got_done), 32'd1);
    chk("xfers", 32'(xfers), 32'(L * n / 2));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef FFT_BITREV_EN
    chk("br_count", 32'(br_obs.size()), 32'(n));
    foreach (br_obs[x]) begin
      int r = 0;
      for (int b = 0; b < L; b++)
        if (((x >> b) & 1) != 0) r = r | (1 << (L - 1 - b));
      chk("br_addr", 32'(br_obs[x]), 32'(r));
      ri++;
    end
`endif
    exp_q.delete();
    bf_ready = 1'b1;
    step();
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  task automatic bad_start(input logic [AW:0] n);
    n_points = n;
    start    = 1'b1;
    step();
    start = 1'b0;
    chk("err_pulse", 32'({err, busy, bf_valid}), 32'b100);
    step();
    chk("err_clear", 32'({err, busy, bf_valid}), 32'b000);
  endtask

  initial begin
    int w;
    rst      = 1'b1;
    start    = 1'b0;
    n_points = '0;
    fmt_in   = 1'b0;
    bf_ready = 1'b0;
    step();
    step();
    chk("reset_outs", all_outs(), 32'd0);
    rst = 1'b0;
    step();

    run_fft(8, 1'b1, 1'b0);
    bad_start(6'd12);
    bad_start(6'd0);
    run_fft(32, 1'b0, 1'b0);
    run_fft(16, 1'b1, 1'b0);
    run_fft(16, 1'b1, 1'b1);
    run_fft(2, 1'b0, 1'b0);

    n_points = 6'd16;
    fmt_in   = 1'b1;
    bf_ready = 1'b1;
    start    = 1'b1;
    step();
    start = 1'b0;
    w = 0;
    while (!(stage == 3'd2 && bf_valid) && w < 200) begin
      step();
      w++;
    end
    chk("reach_stage2", 32'({bf_valid, stage}), 32'({1'b1, 3'd2}));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_outs", all_outs(), 32'd0);
    step();
    chk("abort_idle", 32'({bf_valid, busy, done}), 32'd0);

    run_fft(4, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Control FSM for the in-place radix-2 DIT FFT engine.
- For a runtime-selected N in {2,4,8,16,32}, walks every stage and butterfly. Per butterfly it emits the two data-memory addresses plus the twiddle index k and size n for the unified twiddle ROM.
- Paces issue with a ready/valid handshake to the butterfly unit. Inserts a pipeline-drain gap between stages so read-after-write hazards cannot occur.

Parameters:
- MAX_N, 32, largest supported transform size (power of 2).
- ADDR_WIDTH, $clog2(MAX_N), data-memory and twiddle-index width.
- BF_LATENCY, 4, cycles from butterfly issue to write-back; sets the inter-stage drain gap.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse to begin a transform; sampled only in IDLE
- n_points  input  ADDR_WIDTH+1  transform size; legal values 2,4,8,16,32
- fmt_in  input  1  data_format_mode request (1=FP8, 0=FP4)
- bf_ready  input  1  butterfly unit can accept an issue this cycle
- bf_valid  output  1  addr_a/addr_b/tw_k/tw_n are valid
- addr_a  output  ADDR_WIDTH  upper butterfly operand address
- addr_b  output  ADDR_WIDTH  lower butterfly operand address (addr_a + half)
- tw_k  output  ADDR_WIDTH  twiddle index to ROM k input
- tw_n  output  ADDR_WIDTH+1  latched N to ROM n input
- tw_fmt  output  1  latched format to ROM data_format_mode
- stage  output  3  current stage index, 0..log2N-1
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse on completion
- err  output  1  one-cycle pulse when start is rejected

Behaviour:
- Reset values (all outputs): bf_valid=0, addr_a=0, addr_b=0, tw_k=0, tw_n=0, tw_fmt=0, stage=0, busy=0, done=0, err=0. FSM goes to IDLE.
- States: IDLE, ISSUE, DRAIN, FINISH.
- IDLE:
  - On start with a legal n_points: latch N, L=log2N, fmt; clear stage and butterfly counter j; go to ISSUE; busy=1 next cycle.
  - On start with an illegal n_points (0, 1, non-power-of-2, >MAX_N): pulse err for 1 cycle and stay in IDLE.
- ISSUE:
  - bf_valid=1 with half=1<<stage, pos=j&(half-1), grp=j>>stage.
  - addr_a=grp*2*half+pos; addr_b=addr_a+half.
  - tw_k=pos<<(L-1-stage); tw_n=N.
  - Outputs are registered and stay stable while bf_valid=1 and bf_ready=0.
  - A transfer occurs when bf_valid and bf_ready are both high. j increments, and the next butterfly is presented the following cycle (1 issue per cycle at full rate).
  - On the transfer with j=N/2-1: bf_valid=0, j clears, go to DRAIN.
- DRAIN:
  - Counts BF_LATENCY cycles with bf_valid=0.
  - Then, if stage==L-1, go to FINISH. Otherwise stage++ and return to ISSUE.
- FINISH: pulse done for 1 cycle, busy=0, go to IDLE.
- start outside IDLE is ignored; no err pulse.
- Latched N and fmt are unaffected by input changes during a transform.
- N=2: single stage with one butterfly (addr 0/1, k=0), then DRAIN, then FINISH.
- Total cycles from start to done at bf_ready=1: L*(N/2+BF_LATENCY)+2.
- rst asserted mid-transform: aborts on the next edge; all outputs return to reset values with no done pulse.

Optional Feature:
- Macro FFT_BITREV_EN.
- When defined:
  - Adds outputs br_valid (1) and br_addr (ADDR_WIDTH), plus a BITREV state entered from the final DRAIN in place of FINISH.
  - BITREV emits br_addr = bit-reverse of an index i over L bits, for i=0..N-1, one per cycle while bf_ready=1. It reuses the same handshake and holds while bf_ready=0.
  - br_valid=1 during this phase; then go to FINISH.
  - Reset values: br_valid=0, br_addr=0.
- When undefined: no such ports or state, and the final DRAIN goes directly to FINISH.

Test Plan:
- N=8, fmt=1, bf_ready=1, BF_LATENCY=4:
  - stage0 pairs (0,1),(2,3),(4,5),(6,7) with k=0.
  - stage1 pairs (0,2),(1,3),(4,6),(5,7) with k=0,2,0,2.
  - stage2 pairs (0,4),(1,5),(2,6),(3,7) with k=0,1,2,3.
  - tw_n=8, tw_fmt=1, done exactly 26 cycles after start.
- N=32: 80 total issues; stage4 tw_k runs 0..15, addr_b=addr_a+16; no bf_valid during the 4-cycle gaps between stages.
- Random bf_ready toggling at N=16: addr_a, addr_b and tw_k are held while stalled; the issue sequence is identical to the unstalled run; exactly 32 transfers.
- start with n_points=12, then start with n_points=0: err pulses each time, busy stays 0, no bf_valid.
- rst pulsed during stage 2 of N=16: next cycle all outputs are 0 and state is IDLE; a fresh start with N=4 completes correctly.
- FFT_BITREV_EN, N=8: after the last drain, br_addr sequence is 0,4,2,6,1,5,3,7, then done.
